// File: rtl/transmitter_spi.sv
// SPI master: frames data_in out on MOSI (LSB first) while capturing MISO into data_out.
// Latency: SS falls 1 cycle after start; done at 1 + HALF_PERIOD*(2*FRAME_BITS+1) cycles.
// Backpressure: none; start is accepted only in IDLE and dropped while busy (no queueing).
module transmitter_spi #(
  parameter int DATA_W      = 16,
  parameter int FRAME_BITS  = 16,
  parameter int HALF_PERIOD = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CKP,
  input  logic              CPH,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              MISO,
  output logic              SCK,
  output logic              SS,
  output logic              MOSI,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done
);

  // Total SCK edges per frame; counters are sized so they never wrap.
  localparam int EDGES  = 2 * FRAME_BITS;
  localparam int EDGE_W = $clog2(EDGES + 1);
  localparam int DIV_W  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    TRANSFER,
    FINISH
  } state_t;

  state_t              state_q;
  logic [DIV_W-1:0]    div_q;
  logic [EDGE_W-1:0]   edge_q;
  logic [DATA_W-1:0]   tx_sr_q;
  logic [DATA_W-1:0]   rx_sr_q;
  logic                ckp_q;
  logic                cph_q;
  logic                sck_q;
  logic                ss_q;
  logic                mosi_q;
  logic                busy_q;
  logic                done_q;
  logic [DATA_W-1:0]   data_out_q;

  logic                tick_d;
  logic [EDGE_W-1:0]   edge_num_d;
  logic                sample_d;
  logic                last_d;
  logic [DATA_W-1:0]   tx_rot_d;
  logic [DATA_W-1:0]   rx_shift_d;

  // Decode of the SCK edge about to be produced: its number, role and the shifted registers.
  always_comb begin
    tick_d     = (div_q == DIV_W'(HALF_PERIOD - 1));
    // SETUP's terminal tick produces edge 1; TRANSFER ticks produce the following ones.
    edge_num_d = (state_q == SETUP) ? EDGE_W'(1) : edge_q + EDGE_W'(1);
    // Odd edges are leading. CPH=0 samples on leading, CPH=1 samples on trailing.
    sample_d   = edge_num_d[0] ^ cph_q;
    last_d     = (edge_num_d == EDGE_W'(EDGES));
    // Rotation (not plain shift) lets MOSI recirculate the word through a daisy chain.
    tx_rot_d   = (tx_sr_q >> 1) | (tx_sr_q << (DATA_W - 1));
    // MISO enters at the MSB so the first sampled bit ends up at bit 0.
    rx_shift_d = (rx_sr_q >> 1) | (DATA_W'(MISO) << (DATA_W - 1));
  end

  // Frame sequencer: IDLE -> SETUP -> TRANSFER -> FINISH, all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      edge_q     <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      ckp_q      <= 1'b0;
      cph_q      <= 1'b0;
      sck_q      <= CKP;
      ss_q       <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_out_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          sck_q <= CKP;
          ss_q  <= 1'b1;
          if (start) begin
            // Mode and data are frozen here; later CKP/CPH changes are ignored until IDLE.
            ckp_q   <= CKP;
            cph_q   <= CPH;
            tx_sr_q <= data_in;
            ss_q    <= 1'b0;
            busy_q  <= 1'b1;
            div_q   <= '0;
            edge_q  <= '0;
            state_q <= SETUP;
            // CPH=0 slaves sample on the first edge, so bit 0 must be valid at SS fall.
            if (!CPH) begin
              mosi_q <= data_in[0];
            end
          end
        end

        SETUP, TRANSFER: begin
          if (tick_d) begin
            div_q  <= '0;
            sck_q  <= ~sck_q;
            edge_q <= edge_num_d;
            if (sample_d) begin
              rx_sr_q <= rx_shift_d;
            end else if (cph_q && (edge_num_d == EDGE_W'(1))) begin
              // CPH=1 drives bit 0 on the first leading edge without rotating.
              mosi_q <= tx_sr_q[0];
            end else if (!last_d) begin
              // The final CPH=0 trailing edge has no next bit to present.
              tx_sr_q <= tx_rot_d;
              mosi_q  <= tx_rot_d[0];
            end
            state_q <= last_d ? FINISH : TRANSFER;
          end else begin
            if (state_q == SETUP) begin
              sck_q <= ckp_q;
            end
            div_q <= div_q + DIV_W'(1);
          end
        end

        FINISH: begin
          sck_q <= ckp_q;
          if (tick_d) begin
            div_q      <= '0;
            ss_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            data_out_q <= rx_sr_q;
            state_q    <= IDLE;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign SCK      = sck_q;
  assign SS       = ss_q;
  assign MOSI     = mosi_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_transmitter_spi.sv
// Bench for transmitter_spi: bit-level slave models on the bus, word-level expectations.
// Latency: checks SS/SCK/done cycle positions relative to the start-sample edge.
// Backpressure: exercises ignored start while busy and back-to-back start on done.
module tb_transmitter_spi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ckp, cph, start_a, start_b, miso_a, miso_b;
  logic [15:0] din;
  logic        sck_a, ss_a, mosi_a, busy_a, done_a;
  logic        sck_b, ss_b, mosi_b, busy_b, done_b;
  logic [15:0] dout_a, dout_b;

  transmitter_spi #(.DATA_W(16), .FRAME_BITS(16), .HALF_PERIOD(2)) u_a (
    .clk(clk), .rst(rst), .CKP(ckp), .CPH(cph), .start(start_a), .data_in(din),
    .MISO(miso_a), .SCK(sck_a), .SS(ss_a), .MOSI(mosi_a), .data_out(dout_a),
    .busy(busy_a), .done(done_a)
  );

  transmitter_spi #(.DATA_W(16), .FRAME_BITS(32), .HALF_PERIOD(2)) u_b (
    .clk(clk), .rst(rst), .CKP(ckp), .CPH(cph), .start(start_b), .data_in(din),
    .MISO(miso_b), .SCK(sck_b), .SS(ss_b), .MOSI(mosi_b), .data_out(dout_b),
    .busy(busy_b), .done(done_b)
  );

  int total = 0;
  int bad   = 0;
  int c     = 0;

  // Slave models: rxa is the single receiver on bus A; rb[0] is fed by MOSI_B, rb[1] drives MISO_B.
  logic [15:0] rxa;
  logic [15:0] rb [2];
  bit          cph_m;
  int          ea, eb, first_edge_a, last_edge_a, first_edge_b, last_edge_b, mosi_bad;
  logic        prev_sck_a, prev_ss_a, prev_mosi_a, prev_sck_b, prev_ss_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance, then let the slave models react to SCK edges seen on the bus.
  task automatic tick();
    bit   lead, smp, sck_chg, ss_fell;
    logic out0;
    @(posedge clk);
    #1;
    c++;
    // bus A
    smp     = 1'b0;
    sck_chg = (!ss_a && (sck_a !== prev_sck_a));
    ss_fell = (prev_ss_a === 1'b1) && (ss_a === 1'b0);
    if (ss_fell) ea = 0;
    if (sck_chg) begin
      ea++;
      lead = (ea % 2) == 1;
      smp  = cph_m ? !lead : lead;
      if (ea == 1) first_edge_a = c;
      last_edge_a = c;
      if (smp) begin
        rxa    = {mosi_a, rxa[15:1]};
        miso_a = rxa[0];
      end
    end
    if ((mosi_a !== prev_mosi_a) && !ss_fell && !(sck_chg && !smp)) mosi_bad++;
    // bus B: two receivers in a chain
    if ((prev_ss_b === 1'b1) && (ss_b === 1'b0)) eb = 0;
    if (!ss_b && (sck_b !== prev_sck_b)) begin
      eb++;
      lead = (eb % 2) == 1;
      smp  = cph_m ? !lead : lead;
      if (eb == 1) first_edge_b = c;
      last_edge_b = c;
      if (smp) begin
        out0   = rb[0][0];
        rb[0]  = {mosi_b, rb[0][15:1]};
        rb[1]  = {out0, rb[1][15:1]};
        miso_b = rb[1][0];
      end
    end
    prev_sck_a  = sck_a;
    prev_ss_a   = ss_a;
    prev_mosi_a = mosi_a;
    prev_sck_b  = sck_b;
    prev_ss_b   = ss_b;
  endtask

  // Full frame on bus A with timing, data and MOSI-discipline checks.
  task automatic frame_a(input bit k, input bit p, input logic [15:0] d, input logic [15:0] sw,
                         input int restart_c, input bit flip, input bit b2b,
                         input logic [15:0] d2, input logic [15:0] sw2, input bit pre);
    int busy_bad, ss_bad;
    if (!pre) begin
      ckp = k; cph = p; din = d; rxa = sw; miso_a = sw[0];
      tick();
      chk("idle_sck", sck_a, k);
      chk("idle_ss", ss_a, 1);
      start_a = 1'b1;
    end
    cph_m = p; mosi_bad = 0; busy_bad = 0; ss_bad = 0; first_edge_a = 0; last_edge_a = 0;
    tick();
    start_a = 1'b0;
    c = 1;
    chk("ss_fall_c1", ss_a, 0);
    chk("busy_c1", busy_a, 1);
    chk("no_done_c1", done_a, 0);
    while (!done_a && c < 200) begin
      if (c == restart_c) start_a = 1'b1;
      if (flip && c == 20) begin ckp = !k; cph = !p; end
      tick();
      start_a = 1'b0;
      if (!done_a) begin
        if (ss_a !== 1'b0) ss_bad++;
        if (busy_a !== 1'b1) busy_bad++;
      end
    end
    chk("done_cycle", c, 1 + 2 * (2 * 16 + 1));
    chk("ss_low_window", ss_bad, 0);
    chk("busy_window", busy_bad, 0);
    chk("ss_rise", ss_a, 1);
    chk("busy_fall", busy_a, 0);
    chk("data_out", dout_a, sw);
    chk("first_sck_edge", first_edge_a, 3);
    chk("last_sck_edge", last_edge_a, 65);
    chk("mosi_word", rxa, d);
    chk("mosi_shift_edge_only", mosi_bad, 0);
    chk("sck_idle_end", sck_a, k);
    if (flip) begin ckp = k; cph = p; end
    if (b2b) begin
      din = d2; rxa = sw2; miso_a = sw2[0]; start_a = 1'b1;
    end else begin
      tick();
      chk("done_one_cycle", done_a, 0);
      chk("stays_idle", ss_a, 1);
    end
  endtask

  initial begin
    logic [15:0] pre0, pre1, d2, s2;
    logic [31:0] stream;
    int dones;
    bit k, p;

    rst = 1'b1; ckp = 1'b1; cph = 1'b0; start_a = 1'b0; start_b = 1'b0;
    din = '0; miso_a = 1'b0; miso_b = 1'b0; rxa = '0; rb[0] = '0; rb[1] = '0;
    cph_m = 1'b0; ea = 0; eb = 0; mosi_bad = 0;
    repeat (3) tick();
    chk("rst_ss", ss_a, 1);
    chk("rst_sck_ckp", sck_a, 1);
    chk("rst_mosi", mosi_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_dout", dout_a, 0);
    chk("rst_dout_b", dout_b, 0);
    ckp = 1'b0;
    rst = 1'b0;
    tick();

    // Mode 00 reference frame
    frame_a(1'b0, 1'b0, 16'hA5C3, 16'h1234, 0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    // Modes 01, 10, 11; mode 11 also wiggles CKP/CPH mid-frame
    frame_a(1'b0, 1'b1, 16'h8001, 16'hFFFE, 0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    frame_a(1'b1, 1'b0, 16'h8001, 16'hFFFE, 0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    frame_a(1'b1, 1'b1, 16'h8001, 16'hFFFE, 0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    // Second start at cycle 10 is ignored
    frame_a(1'b0, 1'b0, 16'h3C3C, 16'hBEEF, 10, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);

    // Back-to-back frames with random data
    k = 1'($urandom_range(0, 1)); p = 1'($urandom_range(0, 1));
    d2 = 16'($urandom); s2 = 16'($urandom);
    frame_a(k, p, 16'($urandom), 16'($urandom), 0, 1'b0, 1'b1, d2, s2, 1'b0);
    frame_a(k, p, d2, s2, 0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);

    // Random modes and data
    for (int i = 0; i < 4; i++) begin
      k = 1'($urandom_range(0, 1)); p = 1'($urandom_range(0, 1));
      frame_a(k, p, 16'($urandom), 16'($urandom), 0, 1'(i % 2), 1'b0, 16'h0, 16'h0, 1'b0);
    end

    // Reset mid-frame aborts without done and clears data_out
    ckp = 1'b1; cph = 1'b0; cph_m = 1'b0; din = 16'h1357; rxa = 16'h2468; miso_a = 1'b0;
    tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    c = 1;
    while (c < 30) tick();
    chk("pre_rst_ss_low", ss_a, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_ss", ss_a, 1);
    chk("abort_sck", sck_a, 1);
    chk("abort_busy", busy_a, 0);
    chk("abort_dout", dout_a, 0);
    dones = 0;
    repeat (80) begin
      tick();
      if (done_a) dones++;
    end
    chk("abort_no_done", dones, 0);
    chk("abort_dout_stays", dout_a, 0);

    // Daisy chain: FRAME_BITS=32 through two receivers
    k = 1'($urandom_range(0, 1)); p = 1'($urandom_range(0, 1));
    ckp = k; cph = p; cph_m = p; din = 16'h5A5A;
    pre0 = 16'h00FF; pre1 = 16'hFF00;
    rb[0] = pre0; rb[1] = pre1; miso_b = pre1[0];
    first_edge_b = 0; last_edge_b = 0;
    tick();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    c = 1;
    chk("chain_ss_fall", ss_b, 0);
    while (!done_b && c < 400) tick();
    // The master sees the MISO-end receiver's word first, then the MOSI-end word; it keeps the last 16.
    stream = {pre0, pre1};
    chk("chain_done_cycle", c, 1 + 2 * (2 * 32 + 1));
    chk("chain_data_out", dout_b, stream[31:16]);
    chk("chain_rx0_word", rb[0], 16'h5A5A);
    chk("chain_rx1_word", rb[1], 16'h5A5A);
    chk("chain_first_edge", first_edge_b, 3);
    chk("chain_last_edge", last_edge_b, 1 + 2 * 64);
    chk("chain_ss_rise", ss_b, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
